// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: load-op encodings, datapath defaults and the
// MEM->WB payload record (sized for the widest configuration).
package cpu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int XLEN_MAX = 64;
  localparam int AW_MAX   = 8;

  localparam logic [2:0] LD_B  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_W  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;
  localparam logic [2:0] LD_D  = 3'd5;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_VALID,
    WB_WAIT_LD
  } wb_state_e;

  // Fields are sized for XLEN_MAX/AW_MAX; narrower builds cast on the way in/out.
  typedef struct packed {
    logic                gr_we;
    logic [AW_MAX-1:0]   dest;
    logic [XLEN_MAX-1:0] result;
    logic [31:0]         pc;
    logic                is_load;
    logic [2:0]          ld_op;
    logic [2:0]          addr_lo;
  } mem_wb_payload_t;

endpackage

// File: rtl/ld_align_ext.sv
// Combinational load-lane select and sign/zero extension; shared by WB and
// MEM-stage forwarding.
module ld_align_ext
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      ld_op,
  input  logic [2:0]      addr_lo,
  output logic [XLEN-1:0] ext_data
);

  localparam logic [2:0] LANE_MASK = 3'(XLEN/8 - 1);

  logic [5:0]      shamt;
  logic [XLEN-1:0] lane;

  // Shift the addressed lane down to bit 0, then extend from its natural width.
  always_comb begin
    shamt = {addr_lo & LANE_MASK, 3'b000};
    lane  = rdata >> shamt;
    case (ld_op)
      LD_B:    ext_data = XLEN'($signed(lane[7:0]));
      LD_H:    ext_data = XLEN'($signed(lane[15:0]));
      LD_W:    ext_data = XLEN'($signed(lane[31:0]));
      LD_BU:   ext_data = XLEN'(lane[7:0]);
      LD_HU:   ext_data = XLEN'(lane[15:0]);
      LD_D:    ext_data = rdata;
      default: ext_data = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage_ld.sv
// Writeback stage with load-response wait, flush and orphan-response draining.
// Optional perf counters (wb_retire_cnt, wb_ldwait_cnt) under `define WB_PERF_EN.
module wb_stage_ld
  import cpu_pkg::*;
#(
  parameter  int XLEN      = XLEN_DEF,
  parameter  int NREG      = NREG_DEF,
  parameter  int MAX_OUTST = 2,
  localparam int AW        = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              wb_allowin,
  input  logic              mem_to_wb_valid,
  input  logic              mem_gr_we,
  input  logic [AW-1:0]     mem_dest,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [31:0]       mem_pc,
  input  logic              mem_is_load,
  input  logic [2:0]        mem_ld_op,
  input  logic [2:0]        mem_addr_lo,
  input  logic              data_rdata_ok,
  input  logic [XLEN-1:0]   data_rdata,
  input  logic              wb_flush,
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              wb_valid_o,
  output logic              wb_gr_we_o,
  output logic [AW-1:0]     wb_dest_o,
  output logic              wb_fwd_ok,
  output logic [31:0]       debug_wb_pc,
  output logic [XLEN/8-1:0] debug_wb_rf_we,
  output logic [AW-1:0]     debug_wb_rf_wnum,
  output logic [XLEN-1:0]   debug_wb_rf_wdata
`ifdef WB_PERF_EN
  ,
  output logic [63:0]       wb_retire_cnt,
  output logic [31:0]       wb_ldwait_cnt
`endif
);

  localparam int DW = $clog2(MAX_OUTST + 1);

  mem_wb_payload_t payload;
  logic            wb_valid;
  logic [DW-1:0]   drain_cnt;
  wb_state_e       state;

  logic            live;
  logic            load_hit;
  logic            drain_inc;
  logic            drain_dec;
  logic            accept;
  logic [XLEN-1:0] pl_result;
  logic [AW-1:0]   pl_dest;
  logic [XLEN-1:0] ld_ext;

  ld_align_ext #(.XLEN(XLEN)) u_ld_align_ext (
    .rdata    (data_rdata),
    .ld_op    (payload.ld_op),
    .addr_lo  (payload.addr_lo),
    .ext_data (ld_ext)
  );

  // A response is only the resident load's once every orphaned response has drained.
  always_comb begin
    live      = wb_valid && !reset;
    load_hit  = data_rdata_ok && (drain_cnt == '0);
    pl_result = XLEN'(payload.result);
    pl_dest   = AW'(payload.dest);
    state     = WB_IDLE;
    if (wb_valid)
      state = (payload.is_load && !load_hit) ? WB_WAIT_LD : WB_VALID;
    wb_allowin = !reset && (!wb_valid || (state == WB_VALID) || wb_flush);
    accept     = mem_to_wb_valid && wb_allowin;
    drain_inc  = wb_flush && state == WB_WAIT_LD;
    drain_dec  = data_rdata_ok && (drain_cnt != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid  <= 1'b0;
      payload   <= '0;
      drain_cnt <= '0;
    end else begin
      if (wb_allowin)
        wb_valid <= mem_to_wb_valid;
      if (accept)
        payload <= '{gr_we:   mem_gr_we,
                     dest:    AW_MAX'(mem_dest),
                     result:  XLEN_MAX'(mem_result),
                     pc:      mem_pc,
                     is_load: mem_is_load,
                     ld_op:   mem_ld_op,
                     addr_lo: mem_addr_lo};
      if (drain_inc && !drain_dec && drain_cnt != DW'(MAX_OUTST))
        drain_cnt <= drain_cnt + DW'(1);
      else if (drain_dec && !drain_inc)
        drain_cnt <= drain_cnt - DW'(1);
    end
  end

  // More killed loads than MEM can have outstanding means the handshake broke.
  assert property (@(posedge clk) disable iff (reset)
    !(drain_inc && !drain_dec && drain_cnt == DW'(MAX_OUTST)));

  always_comb begin
    rf_we             = live && payload.gr_we && (state == WB_VALID) && !wb_flush;
    rf_waddr          = reset ? '0 : pl_dest;
    rf_wdata          = reset ? '0 : (payload.is_load ? ld_ext : pl_result);
    wb_valid_o        = live;
    wb_gr_we_o        = live && payload.gr_we;
    wb_dest_o         = rf_waddr;
    wb_fwd_ok         = live && (state == WB_VALID);
    debug_wb_pc       = reset ? '0 : payload.pc;
    debug_wb_rf_we    = {(XLEN/8){rf_we}};
    debug_wb_rf_wnum  = rf_waddr;
    debug_wb_rf_wdata = rf_wdata;
  end

`ifdef WB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_retire_cnt <= '0;
      wb_ldwait_cnt <= '0;
    end else begin
      if (state == WB_VALID && !wb_flush)
        wb_retire_cnt <= wb_retire_cnt + 64'd1;
      if (state == WB_WAIT_LD)
        wb_ldwait_cnt <= wb_ldwait_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_ld.sv
// Directed bench for wb_stage_ld: expected RF writes are queued at issue time
// and a negedge monitor pops and compares every write the DUT performs.
module tb_wb_stage_ld;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_allowin;
  logic        mem_to_wb_valid;
  logic        mem_gr_we;
  logic [4:0]  mem_dest;
  logic [31:0] mem_result;
  logic [31:0] mem_pc;
  logic        mem_is_load;
  logic [2:0]  mem_ld_op;
  logic [2:0]  mem_addr_lo;
  logic        data_rdata_ok;
  logic [31:0] data_rdata;
  logic        wb_flush;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_valid_o;
  logic        wb_gr_we_o;
  logic [4:0]  wb_dest_o;
  logic        wb_fwd_ok;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   compared   = 0;
  int   mismatched = 0;

  wb_stage_ld #(.XLEN(32), .NREG(32), .MAX_OUTST(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .wb_allowin        (wb_allowin),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_gr_we         (mem_gr_we),
    .mem_dest          (mem_dest),
    .mem_result        (mem_result),
    .mem_pc            (mem_pc),
    .mem_is_load       (mem_is_load),
    .mem_ld_op         (mem_ld_op),
    .mem_addr_lo       (mem_addr_lo),
    .data_rdata_ok     (data_rdata_ok),
    .data_rdata        (data_rdata),
    .wb_flush          (wb_flush),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .wb_valid_o        (wb_valid_o),
    .wb_gr_we_o        (wb_gr_we_o),
    .wb_dest_o         (wb_dest_o),
    .wb_fwd_ok         (wb_fwd_ok),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic ld, input logic [2:0] op,
                               input logic [2:0] lo, input logic we, input logic [4:0] dest,
                               input logic [31:0] res, input logic [31:0] pc);
    mem_to_wb_valid = v;
    mem_is_load     = ld;
    mem_ld_op       = op;
    mem_addr_lo     = lo;
    mem_gr_we       = we;
    mem_dest        = dest;
    mem_result      = res;
    mem_pc          = pc;
  endtask

  task automatic loadTxn(input logic [2:0] op, input logic [2:0] lo, input logic [4:0] dest,
                         input logic [31:0] pc, input logic [31:0] data, input int waits,
                         input logic [31:0] expv);
    applyStimulus(1'b1, 1'b1, op, lo, 1'b1, dest, 32'hA5A5_0000, pc);
    exp_q.push_back('{dest, expv, pc});
    @(negedge clk);
    checkOutput("ld_issue_allowin", wb_allowin, 1);
    tick();
    mem_to_wb_valid = 1'b0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      checkOutput("ld_wait_allowin", wb_allowin, 0);
      checkOutput("ld_wait_fwd_ok", wb_fwd_ok, 0);
      tick();
    end
    data_rdata_ok = 1'b1;
    data_rdata    = data;
    @(negedge clk);
    checkOutput("ld_hit_rf_we", rf_we, 1);
    checkOutput("ld_hit_allowin", wb_allowin, 1);
    tick();
    data_rdata_ok = 1'b0;
  endtask

  // Every register-file write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && rf_we) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_write: got waddr=%0d wdata=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("wb_waddr", rf_waddr, mon_e.dest);
        checkOutput("wb_wdata", rf_wdata, mon_e.data);
        checkOutput("wb_pc", debug_wb_pc, mon_e.pc);
        checkOutput("dbg_wdata", debug_wb_rf_wdata, mon_e.data);
        checkOutput("dbg_wnum", debug_wb_rf_wnum, mon_e.dest);
        checkOutput("dbg_we", debug_wb_rf_we, 4'hF);
      end
    end
  end

  initial begin
    reset         = 1'b1;
    wb_flush      = 1'b0;
    data_rdata_ok = 1'b0;
    data_rdata    = '0;
    applyStimulus(1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    @(negedge clk);
    checkOutput("rst_valid", wb_valid_o, 0);
    checkOutput("rst_rf_we", rf_we, 0);
    checkOutput("rst_wdata", rf_wdata, 0);
    checkOutput("rst_pc", debug_wb_pc, 0);
    checkOutput("rst_allowin", wb_allowin, 0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_allowin", wb_allowin, 1);
    checkOutput("post_rst_valid", wb_valid_o, 0);
    tick();

    // back-to-back non-loads
    applyStimulus(1'b1, 1'b0, LD_W, 3'd0, 1'b1, 5'd5, 32'h0000_1234, 32'h0000_0100);
    exp_q.push_back('{5'd5, 32'h0000_1234, 32'h0000_0100});
    @(negedge clk);
    checkOutput("nl1_allowin", wb_allowin, 1);
    tick();
    applyStimulus(1'b1, 1'b0, LD_W, 3'd0, 1'b1, 5'd6, 32'h0000_ABCD, 32'h0000_0104);
    exp_q.push_back('{5'd6, 32'h0000_ABCD, 32'h0000_0104});
    @(negedge clk);
    checkOutput("nl2_allowin", wb_allowin, 1);
    checkOutput("nl2_fwd_ok", wb_fwd_ok, 1);
    checkOutput("nl2_gr_we_o", wb_gr_we_o, 1);
    tick();
    mem_to_wb_valid = 1'b0;
    @(negedge clk);
    checkOutput("nl3_allowin", wb_allowin, 1);
    tick();

    // loads with lane select and extension
    loadTxn(LD_B,  3'd3, 5'd7,  32'h0000_0108, 32'h80FF_0000, 2, 32'hFFFF_FF80);
    loadTxn(LD_HU, 3'd2, 5'd14, 32'h0000_010C, 32'h8001_1234, 0, 32'h0000_8001);
    loadTxn(LD_H,  3'd2, 5'd15, 32'h0000_0110, 32'h8001_1234, 0, 32'hFFFF_8001);
    loadTxn(LD_BU, 3'd0, 5'd16, 32'h0000_0114, 32'h0000_00F0, 1, 32'h0000_00F0);
    loadTxn(LD_H,  3'd0, 5'd17, 32'h0000_0118, 32'h1234_7FFE, 0, 32'h0000_7FFE);

    // flush a waiting load while a non-load enters; its orphaned response must drain
    applyStimulus(1'b1, 1'b1, LD_W, 3'd0, 1'b1, 5'd8, 32'h0, 32'h0000_0120);
    tick();
    wb_flush = 1'b1;
    applyStimulus(1'b1, 1'b0, LD_W, 3'd0, 1'b1, 5'd12, 32'h0000_0099, 32'h0000_0124);
    exp_q.push_back('{5'd12, 32'h0000_0099, 32'h0000_0124});
    @(negedge clk);
    checkOutput("flush_rf_we", rf_we, 0);
    checkOutput("flush_allowin", wb_allowin, 1);
    tick();
    wb_flush = 1'b0;
    applyStimulus(1'b1, 1'b1, LD_W, 3'd0, 1'b1, 5'd9, 32'hA5A5_0000, 32'h0000_0128);
    exp_q.push_back('{5'd9, 32'h0000_5555, 32'h0000_0128});
    tick();
    mem_to_wb_valid = 1'b0;
    data_rdata_ok   = 1'b1;
    data_rdata      = 32'h0000_DEAD;
    @(negedge clk);
    checkOutput("drain_rf_we", rf_we, 0);
    checkOutput("drain_allowin", wb_allowin, 0);
    tick();
    data_rdata = 32'h0000_5555;
    @(negedge clk);
    checkOutput("after_drain_rf_we", rf_we, 1);
    tick();
    data_rdata_ok = 1'b0;

    // flush coinciding with the load's own response: nothing left to drain
    applyStimulus(1'b1, 1'b1, LD_W, 3'd0, 1'b1, 5'd10, 32'h0, 32'h0000_0130);
    tick();
    mem_to_wb_valid = 1'b0;
    wb_flush        = 1'b1;
    data_rdata_ok   = 1'b1;
    data_rdata      = 32'h0000_7777;
    @(negedge clk);
    checkOutput("flush_ok_rf_we", rf_we, 0);
    tick();
    wb_flush      = 1'b0;
    data_rdata_ok = 1'b0;
    loadTxn(LD_W, 3'd0, 5'd11, 32'h0000_0134, 32'h0000_2468, 2, 32'h0000_2468);

    // reset in the middle of a load wait
    applyStimulus(1'b1, 1'b1, LD_W, 3'd0, 1'b1, 5'd13, 32'h0000_3333, 32'h0000_0140);
    tick();
    mem_to_wb_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_allowin", wb_allowin, 0);
    tick();
    reset = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_valid", wb_valid_o, 0);
    checkOutput("mid_rst_rf_we", rf_we, 0);
    tick();
    reset         = 1'b0;
    data_rdata_ok = 1'b1;
    data_rdata    = 32'h0000_BEEF;
    @(negedge clk);
    checkOutput("rst2_valid", wb_valid_o, 0);
    checkOutput("rst2_rf_we", rf_we, 0);
    checkOutput("rst2_wdata", rf_wdata, 0);
    checkOutput("rst2_pc", debug_wb_pc, 0);
    checkOutput("rst2_dest", wb_dest_o, 0);
    checkOutput("rst2_fwd_ok", wb_fwd_ok, 0);
    checkOutput("rst2_allowin", wb_allowin, 1);
    tick();
    data_rdata_ok = 1'b0;

    applyStimulus(1'b1, 1'b0, LD_W, 3'd0, 1'b1, 5'd3, 32'h0000_0042, 32'h0000_0150);
    exp_q.push_back('{5'd3, 32'h0000_0042, 32'h0000_0150});
    tick();
    mem_to_wb_valid = 1'b0;
    tick();
    tick();
    checkOutput("pending_writes", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
